clock12_keeper: RTL and testbench

Running 12-hour timekeeper that consumes the setting FSM's output bundle (propagate, isPM, hours, minutes). On a rising edge of propagate it captures the set time, then advances seconds, minutes, hours and AM/PM from a clk-derived one-second tick. Its outputs drive the display and alarm-compare logic.

---
 rtl/clock12_keeper.sv | 66 ++++++
 tb/tb_clock12_keeper.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clock12_keeper.sv
// clock12_keeper: 12-hour running clock loaded from the time-setter bundle
module clock12_keeper #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CNT_W = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       propagate,
  input  logic       set_isPM,
  input  logic [3:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       run,
  output logic       isPM,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       loaded
);
  logic [CNT_W-1:0] presc;
  logic prop_d, load, tick, sec_wrap, min_wrap;
  logic [3:0] load_hours, next_hours;
  logic [5:0] load_minutes;
  always_comb begin
    load = propagate & ~prop_d;
    tick = run & (presc == CNT_W'(TICKS_PER_SEC - 1));
    sec_wrap = seconds == 6'd59;
    min_wrap = minutes == 6'd59;
    load_hours = (set_hours == 4'd0 || set_hours > 4'd12) ? 4'd12 : set_hours;
    load_minutes = set_minutes > 6'd59 ? 6'd0 : set_minutes;
    next_hours = hours == 4'd12 ? 4'd1 : hours + 4'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prop_d <= 1'b0;
      presc <= '0;
      isPM <= 1'b0;
      hours <= 4'd12;
      minutes <= 6'd0;
      seconds <= 6'd0;
      sec_tick <= 1'b0;
      loaded <= 1'b0;
    end else begin
      prop_d <= propagate;
      if (load) begin
        isPM <= set_isPM;
        hours <= load_hours;
        minutes <= load_minutes;
        seconds <= 6'd0;
        presc <= '0;
        loaded <= 1'b1;
        sec_tick <= 1'b0;
      end else begin
        sec_tick <= tick;
        if (run) presc <= tick ? '0 : presc + CNT_W'(1);
        if (tick) begin
          seconds <= sec_wrap ? 6'd0 : seconds + 6'd1;
          if (sec_wrap) minutes <= min_wrap ? 6'd0 : minutes + 6'd1;
          if (sec_wrap && min_wrap) begin
            hours <= next_hours;
            if (hours == 4'd11) isPM <= ~isPM;
          end
        end
      end
    end
endmodule

// File: tb/tb_clock12_keeper.sv
// tb_clock12_keeper: checks the timekeeper against a seconds-of-day model
module tb_clock12_keeper;
  localparam int TPS = 4;
  logic clk = 0, reset = 1, propagate = 0, set_isPM = 0, run = 0;
  logic [3:0] set_hours = 0;
  logic [5:0] set_minutes = 0;
  logic isPM, sec_tick, loaded;
  logic [3:0] hours;
  logic [5:0] minutes, seconds;
  int total = 0, bad = 0;
  int t = 0, ph = 0, mh = 0, mm = 0;
  bit ld = 0, pd = 0, tk = 0;

  clock12_keeper #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .propagate(propagate), .set_isPM(set_isPM),
    .set_hours(set_hours), .set_minutes(set_minutes), .run(run),
    .isPM(isPM), .hours(hours), .minutes(minutes), .seconds(seconds),
    .sec_tick(sec_tick), .loaded(loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int h12(int s);
    int h = (s / 3600) % 12;
    return h == 0 ? 12 : h;
  endfunction

  // Model time is seconds since midnight; display fields are derived from it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0; ph = 0; ld = 0; pd = 0; tk = 0;
    end else begin
      tk = 0;
      if (propagate && !pd) begin
        mh = (set_hours == 0 || set_hours > 12) ? 12 : int'(set_hours);
        mm = set_minutes > 59 ? 0 : int'(set_minutes);
        t = ((mh % 12) + (set_isPM ? 12 : 0)) * 3600 + mm * 60;
        ph = 0;
        ld = 1;
      end else if (run) begin
        if (ph == TPS - 1) begin
          ph = 0;
          t = (t + 1) % 86400;
          tk = 1;
        end else ph++;
      end
      pd = propagate;
    end
  end

  always @(negedge clk) begin
    chk("m_isPM", isPM, t >= 43200 ? 1 : 0);
    chk("m_hours", hours, h12(t));
    chk("m_minutes", minutes, (t / 60) % 60);
    chk("m_seconds", seconds, t % 60);
    chk("m_sec_tick", sec_tick, tk);
    chk("m_loaded", loaded, ld);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(bit pm, int h, int m);
    @(negedge clk) propagate = 0;
    @(negedge clk);
    set_isPM = pm;
    set_hours = 4'(h);
    set_minutes = 6'(m);
    propagate = 1;
    @(negedge clk);
  endtask

  task automatic lit(string nm, int pm, int h, int m, int s, int l);
    chk({nm, "_isPM"}, isPM, pm);
    chk({nm, "_hours"}, hours, h);
    chk({nm, "_minutes"}, minutes, m);
    chk({nm, "_seconds"}, seconds, s);
    chk({nm, "_loaded"}, loaded, l);
  endtask

  initial begin
    run = 1;
    #12 lit("reset", 0, 12, 0, 0, 0);
    chk("reset_tick", sec_tick, 0);
    @(negedge clk) reset = 0;
    do_load(1, 3, 45);
    lit("load345", 1, 3, 45, 0, 1);
    cyc(3);
    chk("pre_tick", sec_tick, 0);
    chk("pre_tick_s", seconds, 0);
    cyc(1);
    chk("first_tick", sec_tick, 1);
    chk("first_tick_s", seconds, 1);
    cyc(1);
    chk("tick_pulse", sec_tick, 0);
    cyc(19);
    lit("held", 1, 3, 45, 6, 1);
    do_load(0, 11, 59);
    cyc(240);
    lit("am_to_pm", 1, 12, 0, 0, 1);
    do_load(1, 12, 59);
    cyc(240);
    lit("twelve_to_one", 1, 1, 0, 0, 1);
    do_load(1, 11, 59);
    cyc(240);
    lit("pm_to_am", 0, 12, 0, 0, 1);
    do_load(0, 0, 63);
    lit("sanitise0", 0, 12, 0, 0, 1);
    do_load(1, 13, 10);
    lit("sanitise13", 1, 12, 10, 0, 1);
    do_load(0, 7, 30);
    cyc(2);
    run = 0;
    cyc(10);
    lit("frozen", 0, 7, 30, 0, 1);
    run = 1;
    cyc(1);
    chk("resume_s0", seconds, 0);
    cyc(1);
    chk("resume_s1", seconds, 1);
    chk("resume_tick", sec_tick, 1);
    run = 0;
    do_load(1, 9, 5);
    lit("load_frozen", 1, 9, 5, 0, 1);
    cyc(8);
    lit("still_frozen", 1, 9, 5, 0, 1);
    run = 1;
    do_load(0, 4, 20);
    cyc(2);
    @(posedge clk);
    #2 reset = 1;
    #1 lit("async_rst", 0, 12, 0, 0, 0);
    chk("async_rst_tick", sec_tick, 0);
    @(negedge clk) reset = 0;
    @(negedge clk) propagate = 0;
    @(negedge clk);
    set_isPM = 1; set_hours = 5; set_minutes = 10; propagate = 1;
    #2 reset = 1;
    #1 lit("rst_in_load", 0, 12, 0, 0, 0);
    @(posedge clk);
    #1 lit("rst_held", 0, 12, 0, 0, 0);
    @(negedge clk) reset = 0;
    @(negedge clk);
    lit("post_rst_load", 1, 5, 10, 0, 1);
    cyc(3);
    lit("post_rst_hold", 1, 5, 10, 0, 1);
    cyc(1);
    chk("post_rst_s", seconds, 1);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      run = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) begin
        propagate = ~propagate;
        set_isPM = 1'($urandom);
        set_hours = 4'($urandom_range(0, 15));
        set_minutes = 6'($urandom_range(0, 63));
      end
    end
    cyc(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
